// File: rtl/sa_pkg.sv
// Shared constants, state encoding and skew-index helper for the systolic-array feed controller.
package sa_pkg;

  localparam int N         = 4;
  localparam int DW        = 10;
  localparam int CW        = 2 * DW;
  localparam int DRAIN_LEN = N;
  localparam int IW        = $clog2(N);
  localparam int TW        = $clog2(3 * N);
  localparam int FEED_LAST = 3 * N - 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } feed_t;

  // Element index a lane should present at step t; valid only while 0 <= t-lane < N.
  function automatic feed_t feed_idx(input logic [TW-1:0] t, input logic [IW-1:0] lane);
    feed_t         r;
    logic [TW-1:0] d;
    d     = t - TW'(lane);
    r.vld = (t >= TW'(lane)) && (d < TW'(N));
    r.idx = d[IW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One operand lane: selects the skewed element of its buffer row/column, zero outside its window.
module sa_skew_lane
  import sa_pkg::*;
(
  input  logic [TW-1:0]   t,
  input  logic            active,
  input  logic [IW-1:0]   lane,
  input  logic [N*DW-1:0] vec,
  output logic [DW-1:0]   elem
);

  feed_t sel_s;

  assign sel_s = feed_idx(t, lane);

  // Element select with zero gating outside the feed window
  always_comb begin
    elem = '0;
    if (active && sel_s.vld) begin
      elem = vec[int'(sel_s.idx) * DW +: DW];
    end else begin
      elem = '0;
    end
  end

endmodule

// File: rtl/sa_feed_ctrl.sv
// Feed sequencer for an N x N systolic multiplier: buffers A/B, clears the array, drives skewed wavefronts.
// Optional SA_RUN_COUNT_EN adds a 16-bit completed-run counter output (run_cnt).
module sa_feed_ctrl
  import sa_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            sa_clr,
  output logic [N*DW-1:0] a_bus,
  output logic [N*DW-1:0] b_bus
`ifdef SA_RUN_COUNT_EN
  ,
  output logic [15:0]     run_cnt
`endif
);

  state_t          state_r;
  logic [TW-1:0]   step_r;
  logic [DW-1:0]   a_buf_r [N][N];
  logic [DW-1:0]   b_buf_r [N][N];
  logic [N*DW-1:0] a_row_s [N];
  logic [N*DW-1:0] b_col_s [N];
  logic [N*DW-1:0] a_nxt_s;
  logic [N*DW-1:0] b_nxt_s;
  logic [TW-1:0]   lane_t_s;
  logic            lane_act_s;
  logic            wr_ok_s;

  // Lanes look one step ahead so the bus registers show step t during FEED step t.
  assign lane_t_s   = (state_r == CLR) ? {TW{1'b0}} : step_r + TW'(1);
  assign lane_act_s = (state_r == CLR) || ((state_r == FEED) && (step_r != TW'(FEED_LAST)));
  assign wr_ok_s    = (int'(wr_row) < N) && (int'(wr_col) < N);

  genvar gi, gk;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      for (gk = 0; gk < N; gk++) begin : g_el
        assign a_row_s[gi][gk*DW +: DW] = a_buf_r[gi][gk];
        assign b_col_s[gi][gk*DW +: DW] = b_buf_r[gk][gi];
      end

      sa_skew_lane u_a_lane (
        .t      (lane_t_s),
        .active (lane_act_s),
        .lane   (IW'(gi)),
        .vec    (a_row_s[gi]),
        .elem   (a_nxt_s[gi*DW +: DW])
      );

      sa_skew_lane u_b_lane (
        .t      (lane_t_s),
        .active (lane_act_s),
        .lane   (IW'(gi)),
        .vec    (b_col_s[gi]),
        .elem   (b_nxt_s[gi*DW +: DW])
      );
    end
  endgenerate

  // Run sequencer, buffer write port and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      step_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sa_clr  <= 1'b0;
      a_bus   <= '0;
      b_bus   <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf_r[r][c] <= '0;
          b_buf_r[r][c] <= '0;
        end
      end
`ifdef SA_RUN_COUNT_EN
      run_cnt <= 16'd0;
`endif
    end else begin
      a_bus <= a_nxt_s;
      b_bus <= b_nxt_s;
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          // A write coinciding with start lands before the run reads the buffers.
          if (wr_en && wr_ok_s) begin
            if (wr_sel) begin
              b_buf_r[wr_row][wr_col] <= wr_data;
            end else begin
              a_buf_r[wr_row][wr_col] <= wr_data;
            end
          end
          if (start) begin
            state_r <= CLR;
            sa_clr  <= 1'b1;
            busy    <= 1'b1;
            step_r  <= '0;
          end
        end
        CLR: begin
          sa_clr  <= 1'b0;
          step_r  <= '0;
          state_r <= FEED;
        end
        FEED: begin
          if (step_r == TW'(FEED_LAST)) begin
            step_r  <= '0;
            state_r <= DRAIN;
          end else begin
            step_r <= step_r + TW'(1);
          end
        end
        DRAIN: begin
          if (step_r == TW'(DRAIN_LEN - 1)) begin
            step_r  <= '0;
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef SA_RUN_COUNT_EN
            run_cnt <= run_cnt + 16'd1;
`endif
          end else begin
            step_r <= step_r + TW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          step_r  <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          sa_clr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
